host_mem_avmm_rr_mux: RTL

- Merges NUM_PORTS Avalon-MM host-memory ports from AFU logic into one Avalon-MM port toward a host channel, for example a group-1 host_chan port.
- Arbitration is burst-aware round-robin. Write bursts are never interleaved.
- Read responses return to the issuing port in order, routed through a port/burst tracking FIFO.
- Sits between the AFU and the platform-provided Avalon host-memory mapping, in the same clock domain.

---
 rtl/host_mem_avmm_rr_mux.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/host_mem_avmm_rr_mux.sv
// Merges NUM_PORTS Avalon-MM host-memory ports onto one port with burst-aware
// round-robin arbitration and in-order routing of read responses.
module host_mem_avmm_rr_mux #(
  parameter int NUM_PORTS       = 2,
  parameter int ADDR_WIDTH      = 42,
  parameter int DATA_WIDTH      = 512,
  parameter int BURST_CNT_WIDTH = 7,
  parameter int MAX_RD_REQS     = 32,
  parameter int PORT_IDX_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]       in_address,
  input  logic [NUM_PORTS-1:0]                  in_read,
  input  logic [NUM_PORTS-1:0]                  in_write,
  input  logic [NUM_PORTS*BURST_CNT_WIDTH-1:0]  in_burstcount,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]       in_writedata,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0]     in_byteenable,
  output logic [NUM_PORTS-1:0]                  in_waitrequest,
  output logic [DATA_WIDTH-1:0]                 in_readdata,
  output logic [NUM_PORTS-1:0]                  in_readdatavalid,
  output logic [ADDR_WIDTH-1:0]                 out_address,
  output logic                                  out_read,
  output logic                                  out_write,
  output logic [BURST_CNT_WIDTH-1:0]            out_burstcount,
  output logic [DATA_WIDTH-1:0]                 out_writedata,
  output logic [DATA_WIDTH/8-1:0]               out_byteenable,
  input  logic                                  out_waitrequest,
  input  logic [DATA_WIDTH-1:0]                 out_readdata,
  input  logic                                  out_readdatavalid,
  output logic                                  err_unexpected_rdv
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int PTR_W = (MAX_RD_REQS > 1) ? $clog2(MAX_RD_REQS) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [PORT_IDX_W-1:0]      port;
    logic [BURST_CNT_WIDTH-1:0] burst;
  } rd_entry_t;

  logic [NUM_PORTS-1:0]       req;
  logic [PORT_IDX_W-1:0]      gnt, nxt_rr, rr_ptr, lock_port;
  logic [PORT_IDX_W:0]        cand;
  logic                       gnt_valid, act, is_read, is_write, accept, push, pop, track;
  logic                       lock_q, fifo_full;
  logic [BURST_CNT_WIDTH-1:0] beat_cnt, beats_done, cur_burst;
  logic [PTR_W-1:0]           wr_ptr, rd_ptr;
  logic [CNT_W-1:0]           fifo_cnt;
  rd_entry_t                  fifo_mem [MAX_RD_REQS];
  rd_entry_t                  head;
  logic [NUM_PORTS-1:0]       head_onehot;

  assign req = in_read | in_write;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    gnt       = '0;
    gnt_valid = 1'b0;
    cand      = '0;
    if (lock_q) begin
      gnt       = lock_port;
      gnt_valid = req[lock_port];
    end else begin
      // Descending scan so the lowest offset from rr_ptr wins.
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        cand = {1'b0, rr_ptr} + (PORT_IDX_W + 1)'(i);
        if (cand >= (PORT_IDX_W + 1)'(NUM_PORTS)) cand = cand - (PORT_IDX_W + 1)'(NUM_PORTS);
        if (req[cand[PORT_IDX_W-1:0]]) begin
          gnt       = cand[PORT_IDX_W-1:0];
          gnt_valid = 1'b1;
        end
      end
    end
  end

  assign nxt_rr    = (gnt == PORT_IDX_W'(NUM_PORTS - 1)) ? '0 : gnt + 1'b1;
  assign is_write  = in_write[gnt];
  assign is_read   = in_read[gnt] & ~in_write[gnt];
  assign fifo_full = (fifo_cnt == CNT_W'(MAX_RD_REQS));
  assign act       = gnt_valid & reset_n;
  assign cur_burst = in_burstcount[gnt*BURST_CNT_WIDTH +: BURST_CNT_WIDTH];

  assign out_address    = in_address[gnt*ADDR_WIDTH +: ADDR_WIDTH];
  assign out_burstcount = cur_burst;
  assign out_writedata  = in_writedata[gnt*DATA_WIDTH +: DATA_WIDTH];
  assign out_byteenable = in_byteenable[gnt*BE_W +: BE_W];
  assign out_write      = act & is_write;
  assign out_read       = act & is_read & ~fifo_full;
  assign accept         = (out_write | out_read) & ~out_waitrequest;
  assign push           = accept & is_read;

  always_comb begin
    in_waitrequest = '1;
    for (int p = 0; p < NUM_PORTS; p++)
      if (accept && gnt == PORT_IDX_W'(p)) in_waitrequest[p] = 1'b0;
  end

  assign head  = fifo_mem[rd_ptr];
  assign track = out_readdatavalid & (fifo_cnt != '0);
  assign pop   = track & ((beats_done + 1'b1) >= head.burst);

  always_comb begin
    head_onehot = '0;
    for (int p = 0; p < NUM_PORTS; p++)
      head_onehot[p] = (head.port == PORT_IDX_W'(p));
  end

  function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(MAX_RD_REQS - 1)) ? '0 : ptr + 1'b1;
  endfunction

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr             <= '0;
      lock_q             <= 1'b0;
      lock_port          <= '0;
      beat_cnt           <= '0;
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      fifo_cnt           <= '0;
      beats_done         <= '0;
      in_readdatavalid   <= '0;
      in_readdata        <= '0;
      err_unexpected_rdv <= 1'b0;
    end else begin
      if (accept) begin
        if (!is_write) begin
          rr_ptr <= nxt_rr;
        end else if (lock_q) begin
          beat_cnt <= beat_cnt - 1'b1;
          if (beat_cnt == BURST_CNT_WIDTH'(1)) begin
            lock_q <= 1'b0;
            rr_ptr <= nxt_rr;
          end
        end else if (cur_burst > BURST_CNT_WIDTH'(1)) begin
          lock_q    <= 1'b1;
          lock_port <= gnt;
          beat_cnt  <= cur_burst - 1'b1;
        end else begin
          rr_ptr <= nxt_rr;
        end
      end

      if (push) wr_ptr <= inc_ptr(wr_ptr);
      if (pop) begin
        rd_ptr     <= inc_ptr(rd_ptr);
        beats_done <= '0;
      end else if (track) begin
        beats_done <= beats_done + 1'b1;
      end
      fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);

      in_readdatavalid <= '0;
      if (track) begin
        in_readdatavalid <= head_onehot;
        in_readdata      <= out_readdata;
      end
      if (out_readdatavalid && fifo_cnt == '0) err_unexpected_rdv <= 1'b1;
    end
  end

  // NOTE: tracker storage is not reset; validity comes solely from the reset pointers and count.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{port: gnt, burst: cur_burst};
  end

endmodule
